// File: rtl/demod_seq.sv
// rtl/demod_seq.sv - IQ demodulator sequencer: ADC strobe, fs/4 LO phase, warm-up blanking, drain
module demod_seq #(
    parameter int DIV       = 5,
    parameter int WARMUP    = 8,
    parameter int DEMOD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        ADC_rdy,
    output logic [1:0]  cosine_out,
    output logic [1:0]  sine_out,
    output logic        bb_valid,
    output logic        busy,
    output logic [1:0]  state_o,
    output logic [15:0] sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_WARMUP = 2'b01,
        S_RUN    = 2'b10,
        S_DRAIN  = 2'b11
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);
    localparam logic [7:0] LAT_LAST  = 8'(DEMOD_LAT - 1);
    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    state_t                 state_q, state_d;
    logic [7:0]             div_q, div_d;       // strobe divider; reused as drain timer in DRAIN
    logic [1:0]             phase_q, phase_d;
    logic [7:0]             warm_q, warm_d;
    logic [DEMOD_LAT-1:0]   dly_q, dly_d;       // RUN strobes in flight through the demod
    logic [15:0]            cnt_q, cnt_d;
    logic                   adc_q, adc_d;
    logic                   busy_q, busy_d;
    logic [3:0]             lo_q, lo_d;         // {cos, sin}
    logic                   push;

    // Next-state logic for sequencer, divider, LO phase and delay line
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        phase_d = phase_q;
        warm_d  = warm_q;
        cnt_d   = cnt_q;
        dly_d   = '0;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_d   = '0;
                phase_d = '0;
                if (en) begin
                    state_d = (WARMUP == 0) ? S_RUN : S_WARMUP;
                    warm_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_WARMUP: begin
                div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
                if (adc_q) begin
                    phase_d = phase_q + 2'd1;
                end
                if (!en) begin
                    // Abort has priority over the WARMUP -> RUN move
                    state_d = S_IDLE;
                    div_d   = '0;
                    phase_d = '0;
                end else if (adc_q) begin
                    warm_d = warm_q + 8'd1;
                    if (warm_q == WARM_LAST) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
                // A strobe visible this cycle is in flight even if en drops at its closing edge
                push  = adc_q;
                if (adc_q) begin
                    phase_d = phase_q + 2'd1;
                end
                if (!en) begin
                    state_d = S_DRAIN;
                    div_d   = '0;
                end
            end
            default: begin
                if (div_q == LAT_LAST) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    phase_d = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
        endcase

        dly_d[0] = push;
        for (int i = 1; i < DEMOD_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
        end
        // sample_cnt moves on the same edge that raises bb_valid
        cnt_d = cnt_d + 16'(dly_d[DEMOD_LAT-1]);
    end

    // Registered output decode so every output is glitch-free
    always_comb begin
        adc_d  = ((state_d == S_WARMUP) || (state_d == S_RUN)) && (div_d == DIV_LAST);
        busy_d = (state_d != S_IDLE);
        case (phase_d)
            2'd0:    lo_d = 4'b0100;
            2'd1:    lo_d = 4'b0001;
            2'd2:    lo_d = 4'b1100;
            default: lo_d = 4'b0011;
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            phase_q <= '0;
            warm_q  <= '0;
            dly_q   <= '0;
            cnt_q   <= '0;
            adc_q   <= 1'b0;
            busy_q  <= 1'b0;
            lo_q    <= 4'b0100;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            warm_q  <= warm_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            adc_q   <= adc_d;
            busy_q  <= busy_d;
            lo_q    <= lo_d;
        end
    end

    assign ADC_rdy    = adc_q;
    assign bb_valid   = dly_q[DEMOD_LAT-1];
    assign busy       = busy_q;
    assign state_o    = state_q;
    assign sample_cnt = cnt_q;
    assign cosine_out = lo_q[3:2];
    assign sine_out   = lo_q[1:0];

endmodule

// File: tb/tb_demod_seq.sv
// tb/tb_demod_seq.sv - self-checking bench for demod_seq against an arithmetic reference model
`timescale 1ns/1ps
module tb_demod_seq;

    localparam int DIV       = 5;
    localparam int WARMUP    = 8;
    localparam int DEMOD_LAT = 1;
    localparam int ST_IDLE = 0, ST_WARM = 1, ST_RUN = 2, ST_DRAIN = 3;
    localparam logic [24:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 16'h0000};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b1;
    logic        ADC_rdy;
    logic [1:0]  cosine_out;
    logic [1:0]  sine_out;
    logic        bb_valid;
    logic        busy;
    logic [1:0]  state_o;
    logic [15:0] sample_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: position in the run is the edge count since start (m_t)
    int m_st, m_t, m_drain_end, m_cnt;
    int m_bb_q[$];
    logic        e_adc, e_bb, e_lo_known;
    logic [1:0]  e_state, e_cos, e_sin;
    logic [15:0] e_cnt;

    demod_seq #(.DIV(DIV), .WARMUP(WARMUP), .DEMOD_LAT(DEMOD_LAT)) dut (
        .clk(clk), .reset(reset), .en(en), .ADC_rdy(ADC_rdy),
        .cosine_out(cosine_out), .sine_out(sine_out), .bb_valid(bb_valid),
        .busy(busy), .state_o(state_o), .sample_cnt(sample_cnt)
    );

    always #10 clk = ~clk;

    function automatic logic [1:0] lo_cos(input int p);
        case (p)
            0: return 2'b01;
            2: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] lo_sin(input int p);
        case (p)
            1: return 2'b01;
            3: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        m_st = ST_IDLE; m_t = 0; m_cnt = 0; m_drain_end = 0;
        m_bb_q.delete();
        e_adc = 1'b0; e_bb = 1'b0; e_state = 2'b00; e_cnt = '0;
        e_cos = 2'b01; e_sin = 2'b00; e_lo_known = 1'b1;
    endtask

    // Drive en, advance one clock, update the model, return at the next falling edge
    task automatic tick(input logic e);
        int p;
        en = e;
        @(posedge clk);
        cyc++;
        case (m_st)
            ST_IDLE: if (e) begin
                m_t = 0; m_cnt = 0;
                m_st = (0 >= WARMUP) ? ST_RUN : ST_WARM;
            end
            ST_WARM, ST_RUN: begin
                if (!e) begin
                    if (m_st == ST_WARM) m_st = ST_IDLE;
                    else begin m_st = ST_DRAIN; m_drain_end = cyc + DEMOD_LAT; end
                end else begin
                    m_t++;
                    m_st = ((m_t / DIV) >= WARMUP) ? ST_RUN : ST_WARM;
                end
            end
            default: if (cyc == m_drain_end) m_st = ST_IDLE;
        endcase
        e_state = 2'(m_st);
        e_adc = ((m_st == ST_WARM) || (m_st == ST_RUN)) && (((m_t + 1) % DIV) == 0);
        if (e_adc && (m_st == ST_RUN)) m_bb_q.push_back(cyc + DEMOD_LAT);
        e_bb = 1'b0;
        if ((m_bb_q.size() > 0) && (m_bb_q[0] == cyc)) begin
            e_bb = 1'b1;
            void'(m_bb_q.pop_front());
            m_cnt = (m_cnt + 1) % 65536;
        end
        e_cnt = 16'(m_cnt);
        e_lo_known = (m_st != ST_DRAIN);
        p = (m_st == ST_IDLE) ? 0 : ((m_t / DIV) % 4);
        e_cos = lo_cos(p);
        e_sin = lo_sin(p);
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        en = 1'b1;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({ADC_rdy, bb_valid, busy, state_o, cosine_out, sine_out, sample_cnt} !== RESET_VEC)
            $display("FAIL reset_async: got %h expected %h",
                     {ADC_rdy, bb_valid, busy, state_o, cosine_out, sine_out, sample_cnt}, RESET_VEC);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({ADC_rdy, bb_valid, busy, state_o, cosine_out, sine_out, sample_cnt} !== RESET_VEC) begin
                errors++;
                $display("FAIL reset_hold: got %h expected %h",
                         {ADC_rdy, bb_valid, busy, state_o, cosine_out, sine_out, sample_cnt}, RESET_VEC);
            end
        end
    endtask

    task automatic test_warmup_run();
        int strobes = 0, run_strobes = 0, first = -1, last = -100, bb_warm = 0;
        reset = 1'b0;
        model_reset();
        for (int i = 1; i <= 150; i++) begin
            tick(1'b1);
            if (i == 1) begin
                checks++;
                if (state_o !== 2'b01) begin
                    errors++; $display("FAIL enter_warmup: got %b expected 01", state_o);
                end
            end
            checks++;
            if ({ADC_rdy, bb_valid, state_o, sample_cnt} !== {e_adc, e_bb, e_state, e_cnt}) begin
                errors++;
                $display("FAIL run_model cyc %0d: got %h expected %h", i,
                         {ADC_rdy, bb_valid, state_o, sample_cnt}, {e_adc, e_bb, e_state, e_cnt});
            end
            if (ADC_rdy === 1'b1) begin
                strobes++;
                if (strobes == 1) first = i;
                else begin
                    checks++;
                    if (i - last != DIV) begin
                        errors++; $display("FAIL strobe_period: got %0d expected %0d", i - last, DIV);
                    end
                end
                last = i;
                if (strobes > WARMUP) run_strobes++;
            end
            if ((strobes <= WARMUP) && (bb_valid === 1'b1)) bb_warm++;
            if ((strobes == WARMUP) && (i == last + 1)) begin
                checks++;
                if (state_o !== 2'b10) begin
                    errors++; $display("FAIL run_after_warmup: got %b expected 10", state_o);
                end
            end
            if ((strobes == WARMUP + 1) && (i == last + 1)) begin
                checks++;
                if ({bb_valid, sample_cnt} !== {1'b1, 16'd1}) begin
                    errors++; $display("FAIL first_bb: got %h expected %h", {bb_valid, sample_cnt}, {1'b1, 16'd1});
                end
            end
            if ((run_strobes == 20) && (i == last + 1)) begin
                checks++;
                if (sample_cnt !== 16'd20) begin
                    errors++; $display("FAIL sample_cnt_20: got %0d expected 20", sample_cnt);
                end
            end
        end
        checks++;
        if (first != DIV) begin
            errors++; $display("FAIL first_strobe_cycle: got %0d expected %0d", first, DIV);
        end
        checks++;
        if (bb_warm != 0) begin
            errors++; $display("FAIL bb_in_warmup: got %0d expected 0", bb_warm);
        end
    endtask

    task automatic test_drain();
        int n = 0, bb_seen = 0, adc_seen = 0;
        while ((ADC_rdy !== 1'b1) && (n < 2 * DIV)) begin
            tick(1'b1);
            n++;
        end
        checks++;
        if (ADC_rdy !== 1'b1) begin
            errors++; $display("FAIL drain_find_strobe: got %b expected 1", ADC_rdy);
        end
        tick(1'b1);
        if (bb_valid === 1'b1) bb_seen++;
        tick(1'b0);
        checks++;
        if (state_o !== 2'b11) begin
            errors++; $display("FAIL drain_state: got %b expected 11", state_o);
        end
        if (bb_valid === 1'b1) bb_seen++;
        if (ADC_rdy === 1'b1) adc_seen++;
        tick(1'b0);
        checks++;
        if ({state_o, busy, cosine_out, sine_out} !== {2'b00, 1'b0, 2'b01, 2'b00}) begin
            errors++;
            $display("FAIL drain_to_idle: got %h expected %h", {state_o, busy, cosine_out, sine_out},
                     {2'b00, 1'b0, 2'b01, 2'b00});
        end
        for (int i = 0; i < 10; i++) begin
            if (bb_valid === 1'b1) bb_seen++;
            if (ADC_rdy === 1'b1) adc_seen++;
            tick(1'b0);
        end
        checks++;
        if ({bb_seen, adc_seen} != {32'd1, 32'd0}) begin
            errors++; $display("FAIL drain_counts: got bb %0d adc %0d expected bb 1 adc 0", bb_seen, adc_seen);
        end
    endtask

    task automatic test_warmup_abort();
        int strobes = 0, n = 0, bb_seen = 0;
        while ((strobes < 3) && (n < 5 * DIV)) begin
            tick(1'b1);
            n++;
            if (ADC_rdy === 1'b1) strobes++;
            if (bb_valid === 1'b1) bb_seen++;
        end
        checks++;
        if (strobes != 3) begin
            errors++; $display("FAIL abort_strobes: got %0d expected 3", strobes);
        end
        tick(1'b0);
        checks++;
        if ({state_o, cosine_out, sine_out} !== {2'b00, 2'b01, 2'b00}) begin
            errors++; $display("FAIL abort_idle: got %h expected %h", {state_o, cosine_out, sine_out},
                               {2'b00, 2'b01, 2'b00});
        end
        for (int i = 0; i < 6; i++) begin
            if ((bb_valid === 1'b1) || (ADC_rdy === 1'b1)) bb_seen++;
            tick(1'b0);
        end
        checks++;
        if (bb_seen != 0) begin
            errors++; $display("FAIL abort_quiet: got %0d expected 0", bb_seen);
        end
    endtask

    task automatic test_lo_phase();
        logic [3:0] exp_lo [5] = '{4'b0100, 4'b0001, 4'b1100, 4'b0011, 4'b0100};
        logic [3:0] got_lo [5];
        int k = 0;
        for (int i = 0; i < 6 * DIV; i++) begin
            tick(1'b1);
            if ((ADC_rdy === 1'b1) && (k < 5)) begin
                got_lo[k] = {cosine_out, sine_out};
                k++;
            end
        end
        checks++;
        if (k != 5) begin
            errors++; $display("FAIL lo_strobe_count: got %0d expected 5", k);
        end
        for (int i = 0; i < k; i++) begin
            checks++;
            if (got_lo[i] !== exp_lo[i]) begin
                errors++; $display("FAIL lo_phase strobe %0d: got %b expected %b", i + 1, got_lo[i], exp_lo[i]);
            end
        end
        tick(1'b0);
    endtask

    task automatic test_random();
        int left = 0;
        logic e_v = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (left == 0) begin
                e_v = ~e_v;
                left = e_v ? int'($urandom_range(1, 130)) : int'($urandom_range(1, 6));
            end
            left--;
            tick(e_v);
            checks++;
            if ({ADC_rdy, bb_valid, busy, state_o, sample_cnt} !==
                {e_adc, e_bb, (e_state != 2'b00), e_state, e_cnt}) begin
                errors++;
                $display("FAIL random cyc %0d: got %h expected %h", i,
                         {ADC_rdy, bb_valid, busy, state_o, sample_cnt},
                         {e_adc, e_bb, (e_state != 2'b00), e_state, e_cnt});
            end
            if (e_lo_known) begin
                checks++;
                if ({cosine_out, sine_out} !== {e_cos, e_sin}) begin
                    errors++;
                    $display("FAIL random_lo cyc %0d: got %b expected %b", i,
                             {cosine_out, sine_out}, {e_cos, e_sin});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        while (((state_o !== 2'b10) || (sample_cnt < 16'd2)) && (n < 200)) begin
            tick(1'b1);
            n++;
        end
        checks++;
        if (state_o !== 2'b10) begin
            errors++; $display("FAIL areset_reach_run: got %b expected 10", state_o);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({ADC_rdy, bb_valid, busy, state_o, cosine_out, sine_out, sample_cnt} !== RESET_VEC) begin
            errors++;
            $display("FAIL areset_immediate: got %h expected %h",
                     {ADC_rdy, bb_valid, busy, state_o, cosine_out, sine_out, sample_cnt}, RESET_VEC);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        tick(1'b1);
        checks++;
        if ({state_o, busy} !== {2'b01, 1'b1}) begin
            errors++; $display("FAIL areset_restart: got %b expected 011", {state_o, busy});
        end
    endtask

    initial begin
        test_reset();
        test_warmup_run();
        test_drain();
        test_warmup_abort();
        test_lo_phase();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demod_seq.md
Name: demod_seq

Overview:
- Sequencer for the IQ demodulator in the Zigbee receive chain.
- Generates the ADC sample strobe (ADC_rdy) that paces the demod.
- Steps the 4-phase fs/4 local oscillator (cosine/sine codes) consumed by the demod.
- Blanks a warm-up window after start, flags valid baseband samples, and drains cleanly on stop.

Parameters:
- DIV, 5, clocks per ADC sample; legal range 2..255.
- WARMUP, 8, strobes discarded after start before baseband is flagged valid; legal range 0..255.
- DEMOD_LAT, 1, clocks from ADC_rdy to demod I_BB/Q_BB update; legal range 1..DIV-1.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  level; 1 = run chain, 0 = stop.
- ADC_rdy  out  1  registered one-cycle sample strobe to ADC capture and demod.
- cosine_out  out  2  LO cosine code, two's complement: +1 = 01, 0 = 00, -1 = 11.
- sine_out  out  2  LO sine code, same encoding.
- bb_valid  out  1  one-cycle pulse; demod I_BB/Q_BB hold a valid sample.
- busy  out  1  1 whenever state is not IDLE.
- state_o  out  2  IDLE = 00, WARMUP = 01, RUN = 10, DRAIN = 11.
- sample_cnt  out  16  count of bb_valid pulses since last start.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; div_cnt = 0; phase = 0; warm_cnt = 0; delay line cleared.
  - All outputs 0, except cosine_out = 01 (phase 0).
- IDLE:
  - div_cnt held at 0; no strobes; phase held at 0.
  - en = 1 sampled at an edge -> WARMUP at that edge; div_cnt = 0, warm_cnt = 0, sample_cnt cleared to 0.
- Strobe generation (WARMUP and RUN):
  - div_cnt counts 0..DIV-1 and wraps.
  - ADC_rdy is registered: high for exactly the one cycle in which div_cnt == DIV-1.
  - Entering WARMUP at edge k gives the first ADC_rdy high between edges k+DIV-1 and k+DIV; then exactly one pulse every DIV cycles.
- LO phase (2-bit counter):
  - Codes held stable throughout the ADC_rdy-high cycle.
  - Phase advances by 1 (mod 4) at the edge that ends each ADC_rdy pulse.
  - Table, phase: cos/sin = 0: 01/00, 1: 00/01, 2: 11/00, 3: 00/11.
- WARMUP:
  - Each strobe increments warm_cnt.
  - The edge ending the WARMUP-th strobe moves to RUN; that strobe is not flagged valid.
  - WARMUP = 0: enter RUN directly from IDLE with the same div_cnt/phase init.
  - en = 0 in WARMUP -> IDLE at next edge; no bb_valid; phase reset to 0.
- RUN:
  - Every strobe is pushed into a DEMOD_LAT-deep delay line.
  - bb_valid pulses exactly DEMOD_LAT cycles after each RUN strobe.
  - sample_cnt increments on each bb_valid and wraps 65535 -> 0.
- en = 0 sampled in RUN -> DRAIN at that edge:
  - No further ADC_rdy; if div_cnt == DIV-1 at that edge, the pending strobe is suppressed.
  - bb_valid for in-flight strobes still issued.
- DRAIN:
  - Runs DEMOD_LAT cycles, then IDLE; phase reset to 0.
  - en is ignored during DRAIN; if en = 1 on arrival in IDLE, restart on the following edge.
- Simultaneous events: reset dominates everything; en is level-sensitive only (no edge detection).

Test Plan (DIV = 5, WARMUP = 8, DEMOD_LAT = 1 unless stated):
- Assert reset 100 ns with en = 1 -> throughout reset: ADC_rdy = 0, bb_valid = 0, busy = 0, state_o = 00, cosine_out = 01, sine_out = 00, sample_cnt = 0.
- Release reset, en = 1 -> state_o = 01 at next edge; ADC_rdy pulses of width 20 ns every 100 ns; first pulse in the 5th cycle.
- Same run -> strobes 1..8 give no bb_valid; state_o = 10 after strobe 8; strobe 9 followed next cycle by bb_valid; sample_cnt = 1; after 20 RUN strobes sample_cnt = 20.
- Track LO over strobes 1..5 -> cos/sin during pulses: 01/00, 00/01, 11/00, 00/11, 01/00.
- Drop en 1 cycle after a RUN strobe -> state_o = 11 for 1 cycle, then 00; exactly one bb_valid for that strobe; no further ADC_rdy; phase back to 0.
- Drop en during WARMUP (after strobe 3) -> IDLE next edge, no bb_valid.
- Assert reset mid-RUN -> all outputs return to reset values asynchronously, before the next edge.
